// File: rtl/uart_alu_tx.sv
// uart_alu_tx: transmit side of the UART ALU host link.
// Accepts a result word on a valid/ready handshake and sends it as NUM_BYTES
// back-to-back 8N1 frames, least-significant byte first.
//
// Ports:
//   clk_i    system clock, rising edge
//   rst_ni   asynchronous reset, active-low
//   data_i   result word to transmit (8*NUM_BYTES bits)
//   valid_i  data_i is valid
//   ready_o  word can be accepted (idle only)
//   tx_o     serial output, idles high, driven from a flop
//   busy_o   a word is being serialized (always !ready_o)
module uart_alu_tx #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned NUM_BYTES    = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [8*NUM_BYTES-1:0] data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   tx_o,
  output logic                   busy_o
);

  localparam int unsigned W  = 8 * NUM_BYTES;
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [BW-1:0]   byte_cnt;
  logic [W-1:0]    shreg;
  logic            tx;
  logic            ready;

  assign tx_o    = tx;
  assign ready_o = ready;
  assign busy_o  = ~ready;

  // The word is shifted right one bit per data bit, so after each byte's
  // eight shifts the next byte already sits in shreg[7:0]. tx is loaded one
  // bit ahead at each boundary so the line only moves on bit edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      ready    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (valid_i) begin
            shreg    <= data_i;
            state    <= START;
            tx       <= 1'b0;
            ready    <= 1'b0;
            baud_cnt <= '0;
            byte_cnt <= '0;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shreg    <= {1'b0, shreg[W-1:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (byte_cnt == BYTE_LAST) begin
              byte_cnt <= '0;
              state    <= IDLE;
              ready    <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              state    <= START;
              tx       <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
